dat_tx_framer: RTL
==================

Name: dat_tx_framer

Overview:
- Transmit-side DAT0 line framer for the SD host data path.
- Sits downstream of the data FIFO and directly upstream of the DAT pad. Replaces the bare parallel-to-serial step in the write path.
- Pops 32-bit words from the FIFO and serialises one SD data block: start bit, N words MSB-first, CRC16 over the data bits, then end bit.
- Reports completion or underrun to the data control FSM.

Parameters:
- MAX_WORDS, 128, maximum words per block (512 bytes); iBlock_words is clamped to this value.
- CRC_INIT, 16'h0000, initial CRC16 register value.

Ports:
- iClock  in  1  system clock; all logic is on the rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iBit_en  in  1  SD bit strobe; exactly one DAT bit advances per cycle in which this is high.
- iStart  in  1  single-cycle request to send one block; sampled only in IDLE.
- iBlock_words  in  8  words in the block, latched on iStart; 0 and values above MAX_WORDS are treated as MAX_WORDS.
- iFIFO_data  in  32  FIFO read data, valid the cycle after oFIFO_read.
- iFIFO_empty  in  1  FIFO empty flag.
- oFIFO_read  out  1  one-cycle FIFO pop strobe.
- oDat  out  1  serial DAT0 value.
- oDat_oe  out  1  pad drive enable; high from start bit through end bit.
- oBusy  out  1  high in any state other than IDLE.
- oDone  out  1  one-cycle pulse after the end bit completes.
- oUnderrun  out  1  one-cycle pulse on FIFO underrun abort.
- oCrc  out  16  final CRC; held until the next iStart.

Behaviour:
- Reset values: oDat=1, oDat_oe=0, oFIFO_read=0, oBusy=0, oDone=0, oUnderrun=0, oCrc=0, state=IDLE.
- Reset mid-frame aborts immediately to these values, with no oDone or oUnderrun pulse.
- The FSM has seven states: IDLE, PREFETCH, START, DATA, CRC, END, DONE.
- IDLE:
  - oDat=1 and oDat_oe=0.
  - iStart latches the word count, loads CRC_INIT into the CRC register and moves to PREFETCH.
- PREFETCH:
  - When iFIFO_empty=0, pulse oFIFO_read.
  - The next cycle captures iFIFO_data into the shift register, then goes to START.
  - Waits indefinitely while the FIFO is empty; no bits have been driven yet.
- START: on iBit_en, drive oDat=0 with oDat_oe=1, then go to DATA.
- DATA:
  - Each iBit_en shifts out one bit, MSB (bit 31) first.
  - Each transmitted bit updates the CRC: CCITT polynomial x^16+x^12+x^5+1 (0x1021), with feedback = crc[15] XOR bit.
  - Prefetch: a word buffer (holding register) is refilled by one oFIFO_read whenever it is empty, more words remain and the FIFO is not empty. It moves into the shift register when bit 0 is sent.
  - Underrun: bit 0 of a non-final word is sent while the buffer is still empty. The block then pulses oUnderrun, drops oDat_oe, forces oDat=1 and returns to IDLE. Any already-popped word is discarded.
  - After bit 0 of the last word, go to CRC.
- CRC: 16 iBit_en strobes shift out the CRC MSB-first; the CRC register is frozen during this phase.
- END: on iBit_en, drive oDat=1, then go to DONE.
- DONE:
  - Drop oDat_oe, pulse oDone, update oCrc, return to IDLE.
  - oBusy falls in the same cycle oDone is high.
- Totals: a frame occupies exactly 32*N+18 iBit_en strobes with oDat_oe high, and performs exactly N oFIFO_read pulses.
- oFIFO_read is never asserted while iFIFO_empty=1, and never more than N times per frame.
- iStart while busy is ignored.
- iBit_en and a FIFO pop in the same cycle are both honoured.

Test Plan:
- N=1, word 0x00000000, iBit_en always high:
  - oDat sequence is 0, then 32 zeros, then 16 zeros, then 1; oCrc=0x0000.
  - oDone 50 cycles after START is entered.
- N=128 (iBlock_words=0), all words 0xFFFFFFFF:
  - oCrc=0x7FA1; 4114 bits are driven; exactly 128 oFIFO_read pulses.
- N=2, words 0xA5A5A5A5 and 0x12345678, iBit_en high 1 cycle in 4:
  - The bit stream matches the reference model, with no bit repeated or skipped.
  - oFIFO_read for word 2 occurs before the last bit of word 1.
- N=4, FIFO empty after 2 words:
  - oUnderrun pulses after bit 0 of word 2 and oDat_oe drops the same cycle.
  - No oDone; the next iStart is accepted.
- iReset low during the CRC phase:
  - All outputs take reset values asynchronously; no oDone.
  - A new frame after release is correct.
- iStart pulsed during DATA:
  - Ignored; latched N unchanged; a single oDone.

Source files
------------

// File: rtl/dat_tx_framer.sv
// Transmit-side DAT0 framer: pops 32-bit words from the data FIFO and serialises one
// SD block as start bit, data MSB-first, CRC16 (x^16+x^12+x^5+1) and end bit.
module dat_tx_framer #(
    parameter int          MAX_WORDS = 128,
    parameter logic [15:0] CRC_INIT  = 16'h0000
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iBit_en,
    input  logic        iStart,
    input  logic [7:0]  iBlock_words,
    input  logic [31:0] iFIFO_data,
    input  logic        iFIFO_empty,
    output logic        oFIFO_read,
    output logic        oDat,
    output logic        oDat_oe,
    output logic        oBusy,
    output logic        oDone,
    output logic        oUnderrun,
    output logic [15:0] oCrc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_START,
        S_DATA,
        S_CRC,
        S_END,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  fetch_left_q;
    logic [7:0]  send_left_q;
    logic [31:0] shift_q;
    logic [31:0] buf_q;
    logic        buf_full_q;
    logic        pend_q;
    logic        starve_q;
    logic [4:0]  bit_idx_q;
    logic [15:0] crc_q;
    logic [15:0] crc_out_q;
    logic        dat_q;
    logic        oe_q;
    logic        busy_q;
    logic        done_q;
    logic        underrun_q;

    logic [7:0]  n_words;
    logic        fifo_read;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign n_words = (iBlock_words == 8'd0 || iBlock_words > 8'(MAX_WORDS))
                   ? 8'(MAX_WORDS) : iBlock_words;

    // At most one pop in flight; data arrives the cycle after the strobe (pend_q).
    always_comb begin
        fifo_read = 1'b0;
        if (!iFIFO_empty && !pend_q && fetch_left_q != 8'd0) begin
            if (state_q == S_PREFETCH) begin
                fifo_read = 1'b1;
            end else if (state_q == S_DATA && !buf_full_q && !starve_q) begin
                fifo_read = 1'b1;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q      <= S_IDLE;
            fetch_left_q <= '0;
            send_left_q  <= '0;
            shift_q      <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            pend_q       <= 1'b0;
            starve_q     <= 1'b0;
            bit_idx_q    <= '0;
            crc_q        <= '0;
            crc_out_q    <= '0;
            dat_q        <= 1'b1;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            pend_q     <= fifo_read;
            if (fifo_read) begin
                fetch_left_q <= fetch_left_q - 8'd1;
            end

            unique case (state_q)
                S_IDLE: begin
                    dat_q <= 1'b1;
                    oe_q  <= 1'b0;
                    if (iStart) begin
                        fetch_left_q <= n_words;
                        send_left_q  <= n_words;
                        crc_q        <= CRC_INIT;
                        buf_full_q   <= 1'b0;
                        starve_q     <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_PREFETCH;
                    end
                end

                S_PREFETCH: begin
                    if (pend_q) begin
                        shift_q   <= iFIFO_data;
                        bit_idx_q <= '0;
                        state_q   <= S_START;
                    end
                end

                S_START: begin
                    if (iBit_en) begin
                        dat_q   <= 1'b0;
                        oe_q    <= 1'b1;
                        state_q <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (starve_q) begin
                        // Bit 0 of a starved word has gone out; abandon the block.
                        underrun_q <= 1'b1;
                        oe_q       <= 1'b0;
                        dat_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        starve_q   <= 1'b0;
                        buf_full_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        if (pend_q) begin
                            buf_q      <= iFIFO_data;
                            buf_full_q <= 1'b1;
                        end
                        if (iBit_en) begin
                            dat_q     <= shift_q[31];
                            crc_q     <= crc_step(crc_q, shift_q[31]);
                            shift_q   <= {shift_q[30:0], 1'b0};
                            bit_idx_q <= bit_idx_q + 5'd1;
                            if (bit_idx_q == 5'd31) begin
                                send_left_q <= send_left_q - 8'd1;
                                if (send_left_q == 8'd1) begin
                                    state_q <= S_CRC;
                                end else if (buf_full_q) begin
                                    shift_q    <= buf_q;
                                    buf_full_q <= 1'b0;
                                end else if (pend_q) begin
                                    // Word landing this very cycle bypasses the buffer.
                                    shift_q    <= iFIFO_data;
                                    buf_full_q <= 1'b0;
                                end else begin
                                    starve_q <= 1'b1;
                                end
                            end
                        end
                    end
                end

                S_CRC: begin
                    if (iBit_en) begin
                        dat_q     <= crc_q[4'd15 - bit_idx_q[3:0]];
                        bit_idx_q <= bit_idx_q + 5'd1;
                        if (bit_idx_q[3:0] == 4'd15) begin
                            state_q <= S_END;
                        end
                    end
                end

                S_END: begin
                    if (iBit_en) begin
                        dat_q     <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        crc_out_q <= crc_q;
                        state_q   <= S_DONE;
                    end
                end

                S_DONE: begin
                    oe_q    <= 1'b0;
                    dat_q   <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oFIFO_read = fifo_read;
    assign oDat       = dat_q;
    assign oDat_oe    = oe_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oUnderrun  = underrun_q;
    assign oCrc       = crc_out_q;

endmodule
